// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit saturating-counter history table plus a
// direct-mapped target table, swept to a known state after every reset.
module branch_predictor #(
    parameter int DWIDTH = 32,
    parameter int IDXW   = 6
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic [DWIDTH-1:0] f_pc,
    output logic              f_pred_taken,
    output logic [DWIDTH-1:0] f_pred_target,
    input  logic              u_valid,
    input  logic [DWIDTH-1:0] u_pc,
    input  logic              u_taken,
    input  logic [DWIDTH-1:0] u_target,
    input  logic              u_pred_taken,
    output logic              mispredict,
    output logic [DWIDTH-1:0] redirect_pc,
    output logic [15:0]       stat_branches,
    output logic [15:0]       stat_mispred
);

    localparam int              DEPTH    = 1 << IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = {IDXW{1'b1}};
    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(3'd4);
    localparam logic [1:0]      CTR_INIT = 2'b01;
    localparam logic [15:0]     STAT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [IDXW-1:0]   ptr_r;
    logic              sweep_done_s;
    logic              upd_en_s;
    logic              wrong_dir_s;
    logic [IDXW-1:0]   f_idx_s;
    logic [IDXW-1:0]   u_idx_s;
    logic              ready_r;
    logic              mispredict_r;
    logic [DWIDTH-1:0] redirect_pc_r;
    logic [15:0]       stat_branches_r;
    logic [15:0]       stat_mispred_r;

    logic [1:0]        ctr_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [DWIDTH-1:0] tgt_r [DEPTH];

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    // Saturating 16-bit statistics increment.
    function automatic logic [15:0] stat_inc(input logic [15:0] cnt);
        return (cnt == STAT_MAX) ? STAT_MAX : cnt + 16'd1;
    endfunction

    assign f_idx_s     = f_pc[IDXW+1:2];
    assign u_idx_s     = u_pc[IDXW+1:2];
    assign wrong_dir_s = u_taken ^ u_pred_taken;

    // Next-state logic: sweep every entry once, then accept updates.
    always_comb begin
        state_next_s = state_r;
        sweep_done_s = 1'b0;
        upd_en_s     = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (ptr_r == LAST_IDX) begin
                    state_next_s = ST_RUN;
                    sweep_done_s = 1'b1;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
                upd_en_s     = u_valid;
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // State register and sweep pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + {{(IDXW-1){1'b0}}, 1'b1};
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Table storage: sweep writes during INIT, training writes during RUN.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == ST_INIT)) begin
            ctr_r[ptr_r]   <= CTR_INIT;
            valid_r[ptr_r] <= 1'b0;
            tgt_r[ptr_r]   <= '0;
        end else if (!reset && upd_en_s) begin
            ctr_r[u_idx_s] <= ctr_step(ctr_r[u_idx_s], u_taken);
            if (u_taken) begin
                valid_r[u_idx_s] <= 1'b1;
                tgt_r[u_idx_s]   <= u_target;
            end
        end
    end

    // Registered resolution outputs and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r         <= 1'b0;
            mispredict_r    <= 1'b0;
            redirect_pc_r   <= '0;
            stat_branches_r <= 16'd0;
            stat_mispred_r  <= 16'd0;
        end else begin
            ready_r      <= ready_r | sweep_done_s;
            mispredict_r <= upd_en_s & wrong_dir_s;
            if (upd_en_s) begin
                redirect_pc_r   <= u_taken ? u_target : (u_pc + PC_STEP);
                stat_branches_r <= stat_inc(stat_branches_r);
                if (wrong_dir_s) begin
                    stat_mispred_r <= stat_inc(stat_mispred_r);
                end
            end
        end
    end

    // Lookup reads the stored entry directly, so a same-cycle update is not bypassed.
    always_comb begin
        f_pred_taken  = 1'b0;
        f_pred_target = '0;
        if (ready_r) begin
            f_pred_taken  = valid_r[f_idx_s] & ctr_r[f_idx_s][1];
            f_pred_target = f_pred_taken ? tgt_r[f_idx_s] : (f_pc + PC_STEP);
        end else begin
            f_pred_taken  = 1'b0;
            f_pred_target = '0;
        end
    end

    assign ready         = ready_r;
    assign mispredict    = mispredict_r;
    assign redirect_pc   = redirect_pc_r;
    assign stat_branches = stat_branches_r;
    assign stat_mispred  = stat_mispred_r;

endmodule
